// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared watch definitions: backlight state encodings and default clock rate
package watch_pkg;

    typedef enum logic [1:0] {
        BL_OFF  = 2'd0,
        BL_ON   = 2'd1,
        BL_FADE = 2'd2
    } bl_state_e;

    // 32.768 kHz watch crystal
    localparam int unsigned CLK_HZ_DEFAULT = 32768;

endpackage

// File: rtl/bl_tick_gen.sv
// rtl/bl_tick_gen.sv - enable-gated divider emitting a one-cycle tick every DIV enabled clocks
// Ports:
//   clk   - clock
//   reset - asynchronous active-low reset
//   clr   - restart the count from zero (wins over en)
//   en    - count this cycle
//   tick  - high in the enabled cycle where the count wraps DIV-1 -> 0
module bl_tick_gen #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // tick does not look at clr, so a consumer may derive clr from tick
    // without forming a combinational loop; callers ignore tick when clearing.
    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/backlight_pwm_ctrl.sv
// rtl/backlight_pwm_ctrl.sv - watch backlight: button-triggered PWM hold with timed linear fade-out
// Ports:
//   clk           - system clock
//   reset         - asynchronous active-low reset
//   btn_backlight - debounced button level; each rising edge is a trigger
//   timeout_s     - hold time in seconds, 0 treated as 1, sampled on each (re)load
//   brightness    - on-level PWM duty code
//   always_on     - hold ON with the timeout frozen while high
//   light         - registered PWM drive
//   active        - registered, high in ON or FADE
module backlight_pwm_ctrl
    import watch_pkg::*;
#(
    parameter int unsigned CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int unsigned TIMEOUT_W   = 4,
    parameter int unsigned PWM_W       = 4,
    parameter int unsigned FADE_CYCLES = 2048
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn_backlight,
    input  logic [TIMEOUT_W-1:0] timeout_s,
    input  logic [PWM_W-1:0]     brightness,
    input  logic                 always_on,
    output logic                 light,
    output logic                 active
);

    localparam logic [TIMEOUT_W-1:0] ONE_S = TIMEOUT_W'(1);

    bl_state_e            state_q, state_d;
    logic                 btn_q;
    logic                 always_on_q;
    logic [TIMEOUT_W-1:0] sec_left_q, sec_left_d;
    logic [PWM_W-1:0]     level_q, level_d;
    logic [PWM_W-1:0]     pwm_cnt_q;
    logic                 light_q, active_q;

    logic                 trig;
    logic                 ao_fall;
    logic [TIMEOUT_W-1:0] hold_load;
    logic                 sec_clr, sec_en, sec_tick;
    logic                 fade_clr, fade_en, fade_tick;
    logic                 light_d, active_d;

    assign trig      = btn_backlight & ~btn_q;
    assign ao_fall   = always_on_q & ~always_on;
    assign hold_load = (timeout_s == '0) ? ONE_S : timeout_s;

    // The seconds prescaler only runs while the hold is actually counting down.
    assign sec_en  = (state_q == BL_ON) && !always_on;
    assign fade_en = (state_q == BL_FADE);

    bl_tick_gen #(.DIV(CLK_HZ)) u_sec_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (sec_clr),
        .en    (sec_en),
        .tick  (sec_tick)
    );

    bl_tick_gen #(.DIV(FADE_CYCLES)) u_fade_div (
        .clk   (clk),
        .reset (reset),
        .clr   (fade_clr),
        .en    (fade_en),
        .tick  (fade_tick)
    );

    always_comb begin
        state_d    = state_q;
        sec_left_d = sec_left_q;
        level_d    = level_q;
        sec_clr    = 1'b0;
        fade_clr   = 1'b0;

        unique case (state_q)
            BL_OFF: begin
                if (trig || always_on) begin
                    state_d    = BL_ON;
                    level_d    = brightness;
                    sec_left_d = hold_load;
                    sec_clr    = 1'b1;
                end
            end
            BL_ON: begin
                level_d = brightness;
                if (always_on) begin
                    // hold frozen; release reloads it below
                end else if (trig || ao_fall) begin
                    // a retrigger in the expiry cycle lands here first and wins
                    sec_left_d = hold_load;
                    sec_clr    = 1'b1;
                end else if (sec_tick) begin
                    sec_left_d = sec_left_q - ONE_S;
                    if (sec_left_q == ONE_S) begin
                        state_d  = BL_FADE;
                        fade_clr = 1'b1;
                    end
                end
            end
            BL_FADE: begin
                if (trig || always_on) begin
                    state_d    = BL_ON;
                    level_d    = brightness;
                    sec_left_d = hold_load;
                    sec_clr    = 1'b1;
                end else if (level_q == '0) begin
                    state_d = BL_OFF;
                end else if (fade_tick) begin
                    level_d = level_q - PWM_W'(1);
                end
            end
            default: begin
                state_d = BL_OFF;
            end
        endcase
    end

    // Compare uses the current level so light tracks the level one cycle late,
    // but the state gate is the next state so active and light switch together.
    assign light_d  = (state_d != BL_OFF) && (pwm_cnt_q < level_q);
    assign active_d = (state_d != BL_OFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= BL_OFF;
            btn_q       <= 1'b0;
            always_on_q <= 1'b0;
            sec_left_q  <= '0;
            level_q     <= '0;
            pwm_cnt_q   <= '0;
            light_q     <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_q       <= btn_backlight;
            always_on_q <= always_on;
            sec_left_q  <= sec_left_d;
            level_q     <= level_d;
            pwm_cnt_q   <= pwm_cnt_q + PWM_W'(1);
            light_q     <= light_d;
            active_q    <= active_d;
        end
    end

    assign light  = light_q;
    assign active = active_q;

endmodule

// File: tb/tb_backlight_pwm_ctrl.sv
// tb/tb_backlight_pwm_ctrl.sv - scoreboard bench for backlight_pwm_ctrl with a clock-count reference model
module tb_backlight_pwm_ctrl;

    localparam int CLK_HZ = 8;
    localparam int FADE_C = 4;
    localparam int PWM_N  = 16;

    localparam int M_OFF  = 0;
    localparam int M_ON   = 1;
    localparam int M_FADE = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn = 1'b0;
    logic       ao = 1'b0;
    logic [3:0] tmo = 4'd3;
    logic [3:0] bright = 4'd8;
    logic       light;
    logic       active;

    backlight_pwm_ctrl #(
        .CLK_HZ      (CLK_HZ),
        .TIMEOUT_W   (4),
        .PWM_W       (4),
        .FADE_CYCLES (FADE_C)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_backlight (btn),
        .timeout_s     (tmo),
        .brightness    (bright),
        .always_on     (ao),
        .light         (light),
        .active        (active)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [1:0] exp_q[$];

    // Reference model: hold measured directly in clocks remaining, fade as
    // clocks elapsed since the last level step.
    int m_state = M_OFF;
    int m_level = 0;
    int m_hold  = 0;
    int m_fk    = 0;
    int m_pwm   = 0;
    bit m_btn   = 1'b0;
    bit m_ao    = 1'b0;
    int ns, nl, nh, nf, full;
    bit trig, fall, e_light, e_active;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        if (!reset) begin
            m_state = M_OFF; m_level = 0; m_hold = 0; m_fk = 0;
            m_pwm = 0; m_btn = 1'b0; m_ao = 1'b0;
            exp_q.delete();
        end else begin
            trig = btn && !m_btn;
            fall = m_ao && !ao;
            full = ((tmo == 4'd0) ? 1 : int'(tmo)) * CLK_HZ;
            ns = m_state; nl = m_level; nh = m_hold; nf = m_fk;
            case (m_state)
                M_OFF: begin
                    if (trig || ao) begin
                        ns = M_ON; nl = int'(bright); nh = full;
                    end
                end
                M_ON: begin
                    nl = int'(bright);
                    if (ao) begin
                        nh = m_hold;
                    end else if (trig || fall) begin
                        nh = full;
                    end else begin
                        nh = m_hold - 1;
                        if (nh == 0) begin
                            ns = M_FADE; nf = 0;
                        end
                    end
                end
                default: begin
                    if (trig || ao) begin
                        ns = M_ON; nl = int'(bright); nh = full;
                    end else if (m_level == 0) begin
                        ns = M_OFF;
                    end else begin
                        nf = m_fk + 1;
                        if (nf == FADE_C) begin
                            nf = 0; nl = m_level - 1;
                        end
                    end
                end
            endcase
            e_active = (ns != M_OFF);
            e_light  = (ns != M_OFF) && (m_pwm < m_level);
            exp_q.push_back({e_light, e_active});
            m_state = ns; m_level = nl; m_hold = nh; m_fk = nf;
            m_pwm = (m_pwm + 1) % PWM_N;
            m_btn = btn; m_ao = ao;
        end
    endtask

    task automatic monitor_step();
        logic [1:0] e;
        if (reset) begin
            if (exp_q.size() == 0) begin
                check("exp_queue_nonempty", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check("light", int'(light), int'(e[1]));
                check("active", int'(active), int'(e[0]));
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; counts consecutive negedges with active high.
    task automatic count_active(output int n_act, output int n_light);
        n_act = 0;
        n_light = 0;
        while (active && n_act < 2000) begin
            n_act++;
            if (light) n_light++;
            @(negedge clk);
        end
    endtask

    task automatic press_count(input string name, input int exp_act);
        int na, nl2;
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        count_active(na, nl2);
        check(name, na, exp_act);
    endtask

    task automatic press();
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
    endtask

    task automatic stimulus();
        int na, nl2, r;

        #1;
        check("reset_light", int'(light), 0);
        check("reset_active", int'(active), 0);
        cyc(3);
        #2 reset = 1'b1;
        cyc(5);

        // basic: 24 ON + 8*4 FADE + 1 cycle at level 0
        bright = 4'd8; tmo = 4'd3;
        press_count("basic_active_len", 57);
        cyc(10);

        tmo = 4'd0;
        press_count("timeout0_active_len", 41);
        cyc(10);

        bright = 4'd0; tmo = 4'd3;
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        count_active(na, nl2);
        check("bright0_active_len", na, 25);
        check("bright0_light_cnt", nl2, 0);
        cyc(10);

        bright = 4'd8; tmo = 4'd3;
        press(); cyc(19);
        press_count("retrigger_active_len", 57);
        cyc(10);

        press(); cyc(45);
        press_count("fade_interrupt_active_len", 57);
        cyc(10);

        press(); cyc(23);
        press_count("retrig_at_expiry_active_len", 57);
        cyc(10);

        ao = 1'b1;
        cyc(100);
        check("always_on_still_active", int'(active), 1);
        ao = 1'b0;
        @(negedge clk);
        count_active(na, nl2);
        check("always_on_release_len", na, 57);
        cyc(10);

        btn = 1'b1;
        @(negedge clk);
        count_active(na, nl2);
        check("held_button_active_len", na, 57);
        cyc(20);
        btn = 1'b0;
        cyc(10);

        press(); cyc(34);
        check("pre_reset_active", int'(active), 1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_light", int'(light), 0);
        check("async_reset_active", int'(active), 0);
        cyc(3);
        #2 reset = 1'b1;
        @(negedge clk);
        na = 0;
        repeat (50) begin
            if (active || light) na++;
            @(negedge clk);
        end
        check("post_reset_idle", na, 0);

        repeat (6000) begin
            r = int'($urandom_range(0, 999));
            if (r < 30) btn = ~btn;
            else if (r < 35) ao = 1'b1;
            else if (r < 55) ao = 1'b0;
            else if (r < 75) bright = 4'($urandom);
            else if (r < 85) tmo = 4'($urandom_range(0, 3));
            @(negedge clk);
        end

        btn = 1'b0; ao = 1'b0;
        cyc(150);
        check("final_idle", int'(active), 0);
    endtask

    initial begin
        fork
            forever begin
                @(posedge clk);
                model_step();
            end
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none
        stimulus();
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/backlight_pwm_ctrl.md
# backlight_pwm_ctrl

Second-generation watch backlight controller: the display backlight turns on at a programmable PWM brightness on a button press. It holds for a programmable number of seconds, then fades linearly to off instead of cutting abruptly. Retrigger, always-on override and a generated 1 Hz timebase are internal, so the block needs only the system clock. It sits between the button debouncer and the LCD backlight driver pin.

## Interface
- `CLK_HZ`, 32768: system clock frequency; sets the seconds prescaler divide ratio.
- `TIMEOUT_W`, 4: width of the `timeout_s` input.
- `PWM_W`, 4: brightness and PWM resolution in bits.
- `FADE_CYCLES`, 2048: clocks per one-level brightness decrement during fade.
- `clk`  in  1: system clock; all logic on the rising edge.
- `reset`  in  1: asynchronous, active-low reset; asserted at 0.
- `btn_backlight`  in  1: debounced, synchronous button level; a rising edge is one trigger.
- `timeout_s`  in  TIMEOUT_W: hold time in seconds, sampled on every trigger; the value 0 is treated as 1.
- `brightness`  in  PWM_W: on-level duty code; 0 means dark.
- `always_on`  in  1: while 1, hold ON with no timeout.
- `light`  out  1: registered PWM drive to the backlight.
- `active`  out  1: registered; 1 in the ON or FADE state.

## Operation
- Reset values: `state`=OFF, `level`=0, `light`=0, `active`=0, all counters 0.
- Edge detect: `trig` = `btn_backlight` & ~`btn_q`, where `btn_q` is a 1-cycle delayed copy of `btn_backlight`.
- FSM states are OFF, ON and FADE.
  - OFF → ON on `trig` or `always_on`.
  - ON → FADE when `sec_left` reaches 0 on a second tick and `always_on`=0.
  - FADE → ON on `trig` or `always_on`.
  - FADE → OFF when `level` reaches 0.
- Entering ON:
  - `level` ← `brightness`.
  - `sec_left` ← max(`timeout_s`, 1).
  - The prescaler is cleared, so the hold is exactly `sec_left`×`CLK_HZ` clocks.
- In ON:
  - `level` tracks `brightness` every cycle.
  - `trig` reloads `sec_left` and clears the prescaler (retrigger).
  - `sec_left` decrements on each prescaler wrap (count `CLK_HZ`-1 → 0).
- `always_on` behaviour:
  - While 1, `sec_left` is frozen.
  - On its falling edge, `sec_left` reloads and the prescaler clears, so the full timeout runs from release.
- In FADE:
  - The fade divider counts 0..`FADE_CYCLES`-1; on each wrap, `level` decrements by 1.
  - `level` never underflows.
  - Entering FADE clears the divider.
- PWM:
  - `pwm_cnt` is a PWM_W-bit free-running counter that wraps at 2^PWM_W.
  - `light` ← (`state`≠OFF) & (`pwm_cnt` < `level`).
  - Duty is `level`/2^PWM_W; the maximum code gives (2^PWM_W-1)/2^PWM_W.
- Boundaries:
  - `brightness`=0: the FSM still runs and `active`=1, but `light` stays 0.
  - FADE entered with `level`=0: go to OFF on the next cycle.
  - `trig` in the same cycle as the timeout expiry: the retrigger wins and the state stays ON.
  - Reset mid-operation: everything returns to reset values immediately.

## Timing
- Trigger latency: `trig` seen in cycle n → `state`=ON and `active`=1 visible at n+1; the first `light` high is at n+1 at the earliest (registered compare against the pre-update `level`, so n+2 in the worst case).
- ON duration: `timeout_s`×`CLK_HZ` clocks from the entry cycle to the FADE entry cycle, ±0.
- Fade duration: `level`×`FADE_CYCLES` clocks, then OFF and `active`=0 one cycle later.
- PWM period: 2^PWM_W clocks.

## Structure
- Shared package `watch_pkg` holds:
  - state encodings `BL_OFF`=2'd0, `BL_ON`=2'd1, `BL_FADE`=2'd2;
  - the default `CLK_HZ`.
- Sub-module `bl_tick_gen` (parameter `DIV`; ports `clk`, `reset`, `clr`, `en`, `tick`) emits a 1-cycle `tick` every `DIV` enabled clocks. It is instantiated twice: as the seconds prescaler and as the fade divider.
- The top level holds the FSM, the `sec_left` counter, `level`, the PWM counter and the output registers.

## Test plan
Directed-test parameters: `CLK_HZ`=8, `FADE_CYCLES`=4, `PWM_W`=4.
- Basic cycle: `timeout_s`=3, `brightness`=8, pulse button → `active`=1 for 24 clocks in ON, then FADE lasting 32 clocks, then OFF; `light` duty is 8/16 during ON.
- Retrigger: second press 20 clocks into ON → FADE starts 24 clocks after the second press (44 after the first).
- Fade interrupt: press during FADE at `level`=3 → back to ON with `level`=8 and a fresh 24-clock hold.
- always_on:
  - assert for 100 clocks → no FADE;
  - deassert → FADE exactly 24 clocks later.
- Edge cases:
  - `timeout_s`=0 → 8-clock hold;
  - `brightness`=0 → `active`=1 with `light`=0 throughout;
  - held button → only one trigger.
- Reset: assert `reset`=0 mid-FADE → `light`, `active` and `level` = 0 asynchronously; no activity after release until the next press.
